data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> ACK, one access per three cycles.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester A has fixed priority.
module data_mem_arbiter #(
    parameter int DEPTH = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic        b_err,
    output logic        mem_write,
    output logic        mem_read,
    output logic [15:0] mem_address,
    output logic [15:0] mem_write_data,
    input  logic [15:0] mem_read_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state;
    logic        l_we;
    logic        l_win_b;
    logic [15:0] l_addr;
    logic [15:0] l_wdata;
    logic        grant_b;
    logic        in_range;
    logic        access;
    logic [15:0] cap_rdata;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_b set means B goes first on the next tie; A wins the first tie after reset.
    logic rr_b;
    assign grant_b = b_req && (!a_req || rr_b);
`else
    assign grant_b = b_req && !a_req;
`endif

    assign in_range  = {1'b0, l_addr} < DEPTH_W;
    assign access    = (state == ACCESS);
    assign busy      = (state != IDLE);
    assign cap_rdata = (in_range && !l_we) ? mem_read_data : 16'h0;

    // Memory strobes exist only for one in-range ACCESS cycle.
    assign mem_write      = access && in_range && l_we;
    assign mem_read       = access && in_range && !l_we;
    assign mem_address    = (access && in_range) ? l_addr  : 16'h0;
    assign mem_write_data = (access && in_range) ? l_wdata : 16'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            l_we    <= 1'b0;
            l_win_b <= 1'b0;
            l_addr  <= 16'h0;
            l_wdata <= 16'h0;
            a_ack   <= 1'b0;
            a_rdata <= 16'h0;
            a_err   <= 1'b0;
            b_ack   <= 1'b0;
            b_rdata <= 16'h0;
            b_err   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_b    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        l_win_b <= grant_b;
                        l_we    <= grant_b ? b_we    : a_we;
                        l_addr  <= grant_b ? b_addr  : a_addr;
                        l_wdata <= grant_b ? b_wdata : a_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_b    <= !grant_b;
`endif
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (l_win_b) begin
                        b_ack   <= 1'b1;
                        b_rdata <= cap_rdata;
                        b_err   <= !in_range;
                    end else begin
                        a_ack   <= 1'b1;
                        a_rdata <= cap_rdata;
                        a_err   <= !in_range;
                    end
                    state <= ACK;
                end
                ACK: begin
                    a_ack   <= 1'b0;
                    a_rdata <= 16'h0;
                    a_err   <= 1'b0;
                    b_ack   <= 1'b0;
                    b_rdata <= 16'h0;
                    b_err   <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
